// File: rtl/my_float_div_pkg.sv
// Shared half-precision constants, FSM encoding and operand classification.
// FLOAT_DIV_ROUND_EN selects round-to-nearest-even; otherwise truncation.
package float_half_pkg;

  localparam int REG_SIZE = 16;
  localparam int EXP_SIZE = 5;
  localparam int FRA_SIZE = 10;
  localparam int BIAS     = 15;
  localparam int Q_BITS   = 14;

  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [15:0] POS_INF = 16'h7C00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_DIVIDE,
    S_ROUND,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    C_ZERO,
    C_SUB,
    C_NORM,
    C_INF,
    C_NAN
  } cls_t;

  typedef struct packed {
    logic              sign;
    logic signed [6:0] exp;
    logic              spec_en;
    logic [15:0]       spec_val;
  } unpk_t;

  function automatic cls_t classify(input logic [15:0] x);
    logic e_zero;
    logic e_ones;
    logic f_zero;
    cls_t c;
    e_zero = (x[14:10] == 5'd0);
    e_ones = (x[14:10] == 5'h1F);
    f_zero = (x[9:0] == 10'd0);
    unique case (1'b1)
      e_zero && f_zero:  c = C_ZERO;
      e_zero && !f_zero: c = C_SUB;
      e_ones && f_zero:  c = C_INF;
      e_ones && !f_zero: c = C_NAN;
      default:           c = C_NORM;
    endcase
    return c;
  endfunction

  function automatic logic rne_inc(
    input logic lsb,
    input logic guard,
    input logic sticky
  );
`ifdef FLOAT_DIV_ROUND_EN
    return guard & (sticky | lsb);
`else
    return 1'b0 & (lsb | guard | sticky);
`endif
  endfunction

endpackage

// File: rtl/my_float_div_if.sv
// Operand/result handshake bundle for the half-precision divider.
// Master drives operands and start; slave returns quotient, busy and done.
interface my_float_div_if;

  logic [15:0] divIn1_44;
  logic [15:0] divIn2_44;
  logic        start_44;
  logic [15:0] divOut_44;
  logic        busy_44;
  logic        d_o_44;

  modport master (
    output divIn1_44,
    output divIn2_44,
    output start_44,
    input  divOut_44,
    input  busy_44,
    input  d_o_44
  );

  modport slave (
    input  divIn1_44,
    input  divIn2_44,
    input  start_44,
    output divOut_44,
    output busy_44,
    output d_o_44
  );

endinterface

// File: rtl/half_frac_div_core.sv
// Restoring 11-bit mantissa divider, one quotient bit per step.
// Produces a 14-bit quotient (1 integer + 13 fraction) and remainder sticky.
module half_frac_div_core
  import float_half_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic [10:0] dividend,
  input  logic [10:0] divisor,
  output logic [13:0] quot,
  output logic        sticky
);

  logic [11:0] rem_q;
  logic [10:0] div_q;
  logic [13:0] quot_q;
  logic        ge;
  logic [10:0] nxt;

  // Remainder stays below the divisor after each step, so 11 bits hold it.
  assign ge  = (rem_q >= {1'b0, div_q});
  assign nxt = ge ? 11'(rem_q - {1'b0, div_q}) : rem_q[10:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q  <= '0;
      div_q  <= '0;
      quot_q <= '0;
    end else if (load) begin
      rem_q  <= {1'b0, dividend};
      div_q  <= divisor;
      quot_q <= '0;
    end else if (step) begin
      quot_q <= {quot_q[Q_BITS-2:0], ge};
      rem_q  <= {nxt, 1'b0};
    end
  end

  assign quot   = quot_q;
  assign sticky = |rem_q;

endmodule

// File: rtl/my_float_div.sv
// Iterative half-precision divider, fixed 17-cycle accept-to-done latency.
// FLOAT_DIV_ROUND_EN enables round-to-nearest-even (default truncates).
module my_float_div
  import float_half_pkg::*;
(
  input  logic          clk_44,
  input  logic          reset_44,
  my_float_div_if.slave bus
);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [15:0] a_q, b_q;
  logic [15:0] res_q, res_d;
  unpk_t       u_q, u_d;
  logic        busy, d_o, load, step;
  logic [13:0] q;
  logic        st;
  logic [10:0] ma, mb;
  cls_t        ca, cb;
  logic        za, zb, ia, ib, na, nb;

  always_ff @(posedge clk_44) begin
    if (!reset_44) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (bus.start_44) state_d = S_UNPACK;
      S_UNPACK: state_d = S_DIVIDE;
      S_DIVIDE: if (cnt_q == 4'(Q_BITS)) state_d = S_ROUND;
      S_ROUND:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // First DIVIDE cycle loads the core, the remaining Q_BITS cycles step it.
  always_comb begin
    busy = 1'b0;
    d_o  = 1'b0;
    load = 1'b0;
    step = 1'b0;
    unique case (state_q)
      S_UNPACK: busy = 1'b1;
      S_DIVIDE: begin
        busy = 1'b1;
        load = (cnt_q == 4'd0);
        step = (cnt_q != 4'd0);
      end
      S_ROUND:  busy = 1'b1;
      S_DONE:   d_o  = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk_44) begin
    if (!reset_44) begin
      a_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      u_q   <= '0;
      res_q <= '0;
    end else begin
      if (state_q == S_IDLE && bus.start_44) begin
        a_q <= bus.divIn1_44;
        b_q <= bus.divIn2_44;
      end
      if (state_q == S_DIVIDE) cnt_q <= cnt_q + 4'd1;
      else                     cnt_q <= '0;
      if (state_q == S_UNPACK) u_q   <= u_d;
      if (state_q == S_ROUND)  res_q <= res_d;
    end
  end

  assign ca = classify(a_q);
  assign cb = classify(b_q);

  // Subnormals are treated exactly like zero from here on.
  always_comb begin
    za = (ca == C_ZERO) || (ca == C_SUB);
    zb = (cb == C_ZERO) || (cb == C_SUB);
    ia = (ca == C_INF);
    ib = (cb == C_INF);
    na = (ca == C_NAN);
    nb = (cb == C_NAN);
    ma = za ? 11'd0 : {1'b1, a_q[9:0]};
    mb = zb ? 11'd0 : {1'b1, b_q[9:0]};
    u_d          = '0;
    u_d.sign     = a_q[15] ^ b_q[15];
    u_d.exp      = $signed({2'b00, a_q[14:10]} - {2'b00, b_q[14:10]}
                           + 7'(BIAS));
    u_d.spec_en  = 1'b1;
    if (na || nb || (za && zb) || (ia && ib))
      u_d.spec_val = QNAN;
    else if (ia || zb)
      u_d.spec_val = POS_INF | {u_d.sign, 15'b0};
    else if (za || ib)
      u_d.spec_val = {u_d.sign, 15'b0};
    else
      u_d.spec_en  = 1'b0;
  end

  half_frac_div_core u_core (
    .clk      (clk_44),
    .rst_n    (reset_44),
    .load     (load),
    .step     (step),
    .dividend (ma),
    .divisor  (mb),
    .quot     (q),
    .sticky   (st)
  );

  logic [9:0]        frac;
  logic [10:0]       frac_r;
  logic              inc;
  logic signed [6:0] e_n, e_f;

  always_comb begin
    if (q[13]) begin
      frac = q[12:3];
      inc  = rne_inc(q[3], q[2], (|q[1:0]) | st);
      e_n  = u_q.exp;
    end else begin
      frac = q[11:2];
      inc  = rne_inc(q[2], q[1], q[0] | st);
      e_n  = u_q.exp - 7'sd1;
    end
    frac_r = {1'b0, frac} + {10'b0, inc};
    e_f    = frac_r[10] ? e_n + 7'sd1 : e_n;
    if (u_q.spec_en)
      res_d = u_q.spec_val;
    else if (e_f >= 7'sd31)
      res_d = POS_INF | {u_q.sign, 15'b0};
    else if (e_f <= 7'sd0)
      res_d = {u_q.sign, 15'b0};
    else
      res_d = {u_q.sign, e_f[4:0], frac_r[9:0]};
  end

  assign bus.divOut_44 = res_q;
  assign bus.busy_44   = busy;
  assign bus.d_o_44    = d_o;

endmodule
